pulse_period_meter: RTL and testbench
=====================================

// Module: pulse_period_meter
// PURPOSE
//  Receive-side counterpart of the DDS square-pulse output: measures an external square
//  wave (e.g. the MSB-derived pulse looped back off-chip) in system clocks.
//  Synchronises the async input, detects edges, and reports period and high-time per cycle.
//  Sits beside the DDS core; host logic compares the result against the programmed tuning word.
// PARAMETERS
//  CW          16  width of period/high-time counters and outputs
//  SYNC_STAGES 2   synchroniser flops on sig_in (>=2)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   asynchronous, active-high reset
//  sig_in       in   1   async square wave under measurement
//  period       out  CW  clocks between last two rising edges
//  high_time    out  CW  clocks sig was high within that period
//  meas_valid   out  1   one-cycle strobe: period/high_time updated
//  overrange    out  1   sticky: a period hit saturation; cleared by next meas_valid
//  no_signal    out  1   see CONFIGURATION
// BEHAVIOUR
//  - Reset: all flops 0; period=0, high_time=0, meas_valid=0, overrange=0, no_signal=0; state=ARM.
//  - sync chain s[SYNC_STAGES-1:0]; s_d = last stage delayed 1; rise = s & ~s_d; fall = ~s & s_d.
//  - Latency: sig_in rising before clk edge k -> rise true in cycle after edge k+SYNC_STAGES-1
//    -> meas_valid high after edge k+SYNC_STAGES (3 clocks for default).
//  - cnt (period counter) and hcnt (high counter), both CW bits, saturate at 2^CW-1, never wrap.
//  - States:
//    ARM:  cnt,hcnt held 0. On rise: cnt<=1, hcnt<=1, -> MEAS. No meas_valid.
//    MEAS: each clk cnt<=cnt+1 (sat); hcnt<=hcnt+1 (sat) while s==1 (incl. rise cycle).
//          On rise with cnt<2^CW-1: period<=cnt, high_time<=hcnt, meas_valid<=1,
//            overrange<=0, cnt<=1, hcnt<=1, stay MEAS.
//          On cnt reaching 2^CW-1 (no rise): overrange<=1, -> ARM (measurement discarded).
//  - Rise and saturation in the same cycle: saturation wins (-> ARM, overrange=1, no strobe).
//  - fall only gates hcnt; a fall with no subsequent rise never produces a strobe.
//  - period/high_time hold their last value between strobes and across overrange.
//  - high_time <= period always; sig stuck high -> saturation path, not high_time=period.
//  - rst mid-measurement: immediate return to reset values, next rise only re-arms.
//  - Input pulses shorter than 1 clk may be missed; minimum measurable period 2 clocks.
// CONFIGURATION
//  PULSE_METER_TIMEOUT_EN defined: no_signal<=1 when state enters ARM via saturation
//    and stays 1 until the next meas_valid (cleared in same cycle meas_valid asserts).
//    no_signal stays 0 after reset until a saturation occurs.
//  Not defined: no_signal tied 0; no extra flops; all other behaviour identical.
// TESTING
//  1 rst, sig_in 50% square period 10 clk -> first rise no strobe; then meas_valid every 10
//    clk with period=10, high_time=5; first strobe 3 clk after 2nd synced rise.
//  2 duty 3/16 (high 3, low 13) -> period=16, high_time=3 every strobe, overrange=0.
//  3 CW=8, sig_in held low 300 clk after a valid period -> overrange=1 at cnt=255, state ARM,
//    period keeps old value; with PULSE_METER_TIMEOUT_EN no_signal=1, without no_signal=0.
//  4 after test 3, resume period 20 -> 1st rise no strobe, 2nd rise meas_valid, period=20,
//    overrange=0, no_signal=0 in same cycle.
//  5 assert rst for 1 clk mid-period (cnt=7) -> outputs 0 immediately; next two rises give one
//    strobe with correct period.
//  6 period change 10->14 on the fly -> strobes report 10 then exactly 14, no intermediate value.

Source files
------------

// File: rtl/pulse_period_meter_if.sv
// rtl/pulse_period_meter_if.sv - signal-under-test input and measurement results of pulse_period_meter
//
// Signals:
//   sig_in      square wave under measurement (asynchronous to clk)
//   period      clocks between the last two rising edges
//   high_time   clocks the signal was high within that period
//   meas_valid  one-cycle strobe, period/high_time just updated
//   overrange   sticky, a period reached counter saturation
//   no_signal   timeout flag (only active with PULSE_METER_TIMEOUT_EN)
// Modports:
//   master  host side: drives sig_in, reads results
//   slave   meter side: reads sig_in, drives results
interface pulse_period_meter_if #(
  parameter int CW = 16
);
  logic          sig_in;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          overrange;
  logic          no_signal;

  modport master (
    output sig_in,
    input  period, high_time, meas_valid, overrange, no_signal
  );

  modport slave (
    input  sig_in,
    output period, high_time, meas_valid, overrange, no_signal
  );
endinterface

// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - measures period and high time of an async square wave in clocks
//
// Synchronises sig_in, detects rising edges and reports, once per input cycle, the number of
// clocks between the last two rising edges and how many of those clocks the signal was high.
// Periods that reach 2^CW-1 clocks are discarded and flagged as overrange.
//
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset
//   mif   pulse_period_meter_if.slave (sig_in in; period, high_time, meas_valid,
//         overrange, no_signal out)
// Parameters:
//   CW           counter/output width
//   SYNC_STAGES  synchroniser depth on sig_in (>= 2)
// Configuration macro:
//   PULSE_METER_TIMEOUT_EN  when defined, no_signal is set on saturation and cleared by the
//                           next measurement; otherwise no_signal is tied low.
module pulse_period_meter #(
  parameter int CW          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pulse_period_meter_if.slave  mif
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {ARM, MEAS} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_dly_q;
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          hcnt_q;
  logic [CW-1:0]          period_q;
  logic [CW-1:0]          high_q;
  logic                   valid_q;
  logic                   ovr_q;

  logic s_d;
  logic rise_d;

  always_comb begin
    s_d    = sync_q[SYNC_STAGES-1];
    rise_d = s_d & ~s_dly_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      s_dly_q  <= 1'b0;
      state_q  <= ARM;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], mif.sig_in};
      s_dly_q <= s_d;
      valid_q <= 1'b0;
      case (state_q)
        ARM: begin
          cnt_q  <= '0;
          hcnt_q <= '0;
          // The arming edge only starts a measurement; there is no earlier edge to pair it with.
          if (rise_d) begin
            cnt_q   <= CNT_ONE;
            hcnt_q  <= CNT_ONE;
            state_q <= MEAS;
          end
        end
        MEAS: begin
          // Saturation is tested before the edge so a rise landing on the saturated count is
          // treated as part of a too-long period and discarded.
          if (cnt_q == CNT_MAX) begin
            ovr_q   <= 1'b1;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            state_q <= ARM;
          end else if (rise_d) begin
            period_q <= cnt_q;
            high_q   <= hcnt_q;
            valid_q  <= 1'b1;
            ovr_q    <= 1'b0;
            // The rise cycle itself is the first (high) clock of the next period.
            cnt_q    <= CNT_ONE;
            hcnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
            if (s_d && (hcnt_q != CNT_MAX)) begin
              hcnt_q <= hcnt_q + CNT_ONE;
            end
          end
        end
        default: state_q <= ARM;
      endcase
    end
  end

  assign mif.period     = period_q;
  assign mif.high_time  = high_q;
  assign mif.meas_valid = valid_q;
  assign mif.overrange  = ovr_q;

`ifdef PULSE_METER_TIMEOUT_EN
  logic nosig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nosig_q <= 1'b0;
    end else if ((state_q == MEAS) && (cnt_q == CNT_MAX)) begin
      nosig_q <= 1'b1;
    end else if ((state_q == MEAS) && rise_d) begin
      nosig_q <= 1'b0;
    end
  end

  assign mif.no_signal = nosig_q;
`else
  assign mif.no_signal = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_period_meter.sv
// tb/tb_pulse_period_meter.sv - self-checking bench for pulse_period_meter
module tb_pulse_period_meter;

  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef PULSE_METER_TIMEOUT_EN
  localparam int EXP_NS  = 1;
`else
  localparam int EXP_NS  = 0;
`endif

  logic clk;
  logic rst;

  pulse_period_meter_if #(.CW(CW)) mif ();

  pulse_period_meter #(.CW(CW), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a record of the input as sampled at each clock edge. A measurement is the
  // distance between two sampled rising edges and the number of high samples between them; it
  // is reported two edges after the closing edge (synchroniser delay). A period is abandoned
  // once it has run CNT_MAX clocks without a closing edge.
  bit hist [65536];
  int n      = 0;
  int m;
  int last   = 0;
  bit armed  = 0;
  int e_per  = 0;
  int e_high = 0;
  bit e_valid = 0;
  bit e_ovr  = 0;
  bit e_ns   = 0;

  int q_per[$];
  int q_high[$];

  always @(posedge clk) begin
    if (rst) begin
      armed = 0; e_valid = 0; e_per = 0; e_high = 0; e_ovr = 0; e_ns = 0;
      hist[n] = 0;
      if (n >= 1) hist[n-1] = 0;
      if (n >= 2) hist[n-2] = 0;
    end else begin
      hist[n] = mif.sig_in;
      e_valid = 0;
      m = n - 2;
      if (armed && (n == last + CNT_MAX + 2)) begin
        e_ovr = 1;
        if (EXP_NS != 0) e_ns = 1;
        armed = 0;
      end else if (m >= 1 && hist[m] && !hist[m-1]) begin
        if (armed) begin
          e_per  = m - last;
          e_high = 0;
          for (int j = last; j < m; j++) e_high += int'(hist[j]);
          e_valid = 1;
          e_ovr   = 0;
          e_ns    = 0;
        end
        armed = 1;
        last  = m;
      end
    end
    n++;
    #1;
    if (mif.meas_valid) begin
      q_per.push_back(int'(mif.period));
      q_high.push_back(int'(mif.high_time));
    end
    checks++;
    if (mif.period !== CW'(e_per) || mif.high_time !== CW'(e_high) || mif.meas_valid !== e_valid ||
        mif.overrange !== e_ovr || mif.no_signal !== e_ns) begin
      errors++;
      $display("FAIL model cycle %0d: got per=%0d high=%0d valid=%b ovr=%b nosig=%b, want per=%0d high=%0d valid=%b ovr=%b nosig=%b",
               n, mif.period, mif.high_time, mif.meas_valid, mif.overrange, mif.no_signal,
               e_per, e_high, e_valid, e_ovr, e_ns);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic wave(input int hi, input int lo);
    mif.sig_in = 1'b1;
    repeat (hi) @(negedge clk);
    mif.sig_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic closing_rise();
    mif.sig_in = 1'b1;
    repeat (4) @(negedge clk);
    mif.sig_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mif.sig_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q_per.delete();
    q_high.delete();
  endtask

  typedef struct {
    int hi;
    int lo;
    int nper;
    int exp_per;
    int exp_high;
  } vec_t;

  vec_t vecs [5];
  int   exp6 [8];

  initial begin
    vecs[0] = '{hi: 5,   lo: 5,   nper: 4, exp_per: 10,  exp_high: 5};
    vecs[1] = '{hi: 3,   lo: 13,  nper: 4, exp_per: 16,  exp_high: 3};
    vecs[2] = '{hi: 1,   lo: 1,   nper: 5, exp_per: 2,   exp_high: 1};
    vecs[3] = '{hi: 10,  lo: 244, nper: 2, exp_per: 254, exp_high: 10};
    vecs[4] = '{hi: 127, lo: 127, nper: 2, exp_per: 254, exp_high: 127};
    exp6    = '{10, 10, 10, 10, 14, 14, 14, 14};

    rst = 1'b1;
    mif.sig_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_period", int'(mif.period), 0);
    check("reset_high", int'(mif.high_time), 0);
    check("reset_valid", int'(mif.meas_valid), 0);
    check("reset_ovr", int'(mif.overrange), 0);
    check("reset_nosig", int'(mif.no_signal), 0);
    rst = 1'b0;

    // Table vectors: steady waves, each measured from a fresh reset.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      repeat (vecs[v].nper) wave(vecs[v].hi, vecs[v].lo);
      closing_rise();
      check($sformatf("tbl%0d_count", v), q_per.size(), vecs[v].nper);
      for (int k = 0; k < q_per.size(); k++) begin
        check($sformatf("tbl%0d_per%0d", v, k), q_per[k], vecs[v].exp_per);
        check($sformatf("tbl%0d_high%0d", v, k), q_high[k], vecs[v].exp_high);
      end
      check($sformatf("tbl%0d_ovr", v), int'(mif.overrange), 0);
    end

    // Signal stops after valid periods, then resumes at period 20.
    do_reset();
    repeat (3) wave(5, 5);
    repeat (300) @(negedge clk);
    check("stop_strobes", q_per.size(), 2);
    check("stop_ovr", int'(mif.overrange), 1);
    check("stop_period_held", int'(mif.period), 10);
    check("stop_nosig", int'(mif.no_signal), EXP_NS);
    q_per.delete();
    q_high.delete();
    repeat (2) wave(10, 10);
    check("resume_strobes", q_per.size(), 1);
    if (q_per.size() > 0) check("resume_period", q_per[0], 20);
    check("resume_ovr", int'(mif.overrange), 0);
    check("resume_nosig", int'(mif.no_signal), 0);

    // Period of exactly 2^CW-1: rise coincides with saturation and is discarded.
    do_reset();
    wave(1, 254);
    wave(1, 254);
    closing_rise();
    check("sat_edge_strobes", q_per.size(), 0);
    check("sat_edge_ovr", int'(mif.overrange), 1);

    // Reset mid-period.
    do_reset();
    repeat (2) wave(5, 5);
    mif.sig_in = 1'b1;
    repeat (3) @(negedge clk);
    mif.sig_in = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_period", int'(mif.period), 10);
    rst = 1'b1;
    #1;
    check("midrst_period", int'(mif.period), 0);
    check("midrst_high", int'(mif.high_time), 0);
    check("midrst_valid", int'(mif.meas_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    q_per.delete();
    q_high.delete();
    repeat (3) @(negedge clk);
    wave(5, 5);
    closing_rise();
    check("post_rst_strobes", q_per.size(), 1);
    if (q_per.size() > 0) check("post_rst_period", q_per[0], 10);

    // Period change 10 -> 14 on the fly.
    do_reset();
    repeat (4) wave(5, 5);
    repeat (4) wave(7, 7);
    closing_rise();
    check("chg_count", q_per.size(), 8);
    for (int k = 0; k < q_per.size() && k < 8; k++)
      check($sformatf("chg_per%0d", k), q_per[k], exp6[k]);

    // Randomised waves, including occasional over-long gaps, against the model.
    do_reset();
    for (int r = 0; r < 40; r++) begin
      int hi;
      int lo;
      hi = $urandom_range(20, 1);
      lo = ($urandom_range(7, 0) == 0) ? $urandom_range(300, 240) : $urandom_range(20, 1);
      wave(hi, lo);
    end
    closing_rise();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
